max_pool_flatten: RTL and testbench

//  2x2/stride-2 signed max-pool over a raster-streamed IN_H x IN_W feature map; writes the

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/pool_row_buffer.sv | 37 +++
 rtl/max_pool_flatten.sv | 108 ++++++++++
 tb/tb_max_pool_flatten.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants, sample type and pool/FC handshake state.
// Imported by the pooling stage and by the fully-connected stage that consumes N_OUT/DATA_W.
package cnn_pkg;

  localparam int DATA_W = 22;
  localparam int IN_W   = 30;
  localparam int IN_H   = 30;
  localparam int OUT_W  = IN_W / 2;
  localparam int OUT_H  = IN_H / 2;
  localparam int N_OUT  = OUT_W * OUT_H;

  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int IDX_W  = $clog2(OUT_W);
  localparam int FLAT_W = $clog2(N_OUT);

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Row buffer for horizontal pair maxima of the even row. Write lands on the next edge, read is
// combinational; no backpressure (the writer decides when to write).
module pool_row_buffer
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sample_t          wr_dat,
  input  logic [IDX_W-1:0] rd_idx,
  output sample_t          rd_dat
);

  sample_t buf_q [OUT_W];
  sample_t buf_d [OUT_W];

  always_comb begin
    buf_d = buf_q;
    if (wr_en) begin
      buf_d[wr_idx] = wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < OUT_W; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

  assign rd_dat = buf_q[rd_idx];

endmodule

// File: rtl/max_pool_flatten.sv
// 2x2/stride-2 signed max-pool of a raster stream into a flattened frame for the FC layer.
// Final write and HOLD entry on the last accept edge; o_ready drops in HOLD until i_release.
module max_pool_flatten
  import cnn_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  sample_t i_data,
  output logic    o_ready,
  input  logic    i_release,
  output logic    o_flat_valid,
  output sample_t o_flat_data [N_OUT],
  output logic    o_overrun
);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  sample_t          pair_q, pair_d;
  logic             overrun_q, overrun_d;
  sample_t          flat_q [N_OUT];
  sample_t          flat_d [N_OUT];

  logic              accept;
  logic              col_odd, row_odd, col_last, row_last;
  logic [IDX_W-1:0]  half_col;
  logic [FLAT_W-1:0] flat_idx;
  sample_t           rb_rd_dat, pair_max, quad_max;

  assign o_ready  = (state_q == ST_FILL);
  assign accept   = i_valid & o_ready;
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign col_last = (col_q == COL_W'(IN_W - 1));
  assign row_last = (row_q == ROW_W'(IN_H - 1));
  assign half_col = IDX_W'(col_q >> 1);
  assign flat_idx = FLAT_W'(row_q >> 1) * FLAT_W'(OUT_W) + FLAT_W'(half_col);
  assign pair_max = smax(pair_q, i_data);
  assign quad_max = smax(rb_rd_dat, pair_max);

  pool_row_buffer u_row_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (accept & ~row_odd & col_odd),
    .wr_idx (half_col),
    .wr_dat (pair_max),
    .rd_idx (half_col),
    .rd_dat (rb_rd_dat)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pair_d    = pair_q;
    flat_d    = flat_q;
    overrun_d = i_valid & ~o_ready;

    if (accept) begin
      // Even column opens a horizontal pair; odd column closes it (buffered or final).
      if (!col_odd) begin
        pair_d = i_data;
      end else if (row_odd) begin
        flat_d[flat_idx] = quad_max;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
        if (row_last) begin
          state_d = ST_HOLD;
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (state_q == ST_HOLD && i_release) begin
      state_d = ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        flat_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pair_q    <= pair_d;
      overrun_q <= overrun_d;
      flat_q    <= flat_d;
    end
  end

  assign o_flat_valid = (state_q == ST_HOLD);
  assign o_flat_data  = flat_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_max_pool_flatten.sv
// Bench for max_pool_flatten: stimulus pushes expected frames/spots/overrun pulses into queues,
// a negedge monitor pops and compares whenever the DUT presents a frame or an overrun pulse.
module tb_max_pool_flatten;
  import cnn_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    i_valid, i_release;
  sample_t i_data;
  logic    o_ready, o_flat_valid, o_overrun;
  sample_t o_flat_data [N_OUT];

  always #5 clk = ~clk;

  max_pool_flatten dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_release    (i_release),
    .o_flat_valid (o_flat_valid),
    .o_flat_data  (o_flat_data),
    .o_overrun    (o_overrun)
  );

  typedef struct { int idx; int val; } spot_t;

  int    checks = 0;
  int    errors = 0;
  int    neg_n = 0;
  int    last_acc_neg = -100;
  int    exp_q[$];
  int    ovr_q[$];
  spot_t spot_q[$];
  int    spot_cnt_q[$];
  int    cur_exp [N_OUT];
  int    hold_bad = 0;
  logic  prev_vld = 1'b0;

  function automatic int pix(int kind, int off, int r, int c);
    if (kind == 1) return -(r * IN_W + c) - 1;
    return r * IN_W + c + off;
  endfunction

  task automatic push_frame(int kind, int off);
    for (int r = 0; r < OUT_H; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        int m;
        m = pix(kind, off, 2 * r, 2 * c);
        for (int d = 1; d < 4; d++) begin
          int v;
          v = pix(kind, off, 2 * r + d / 2, 2 * c + d % 2);
          if (v > m) m = v;
        end
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic push_spot(int idx, int val);
    spot_t s;
    s.idx = idx;
    s.val = val;
    spot_q.push_back(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(string name);
    int bad;
    bad = 0;
    for (int k = 0; k < N_OUT; k++) if (o_flat_data[k] !== '0) bad++;
    checks++;
    if (o_ready !== 1'b1 || o_flat_valid !== 1'b0 || o_overrun !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL %s: ready=%b flat_valid=%b overrun=%b nonzero_entries=%0d, required 1 0 0 0",
               name, o_ready, o_flat_valid, o_overrun, bad);
    end
  endtask

  task automatic send_frame(int kind, int off, int gap_pct, int n_samples, int rel_at);
    for (int s = 0; s < n_samples; s++) begin
      while ($urandom_range(99) < gap_pct) begin
        i_valid = 1'b0;
        step();
      end
      if (s == rel_at) begin
        i_valid   = 1'b0;
        i_release = 1'b1;
        step();
        i_release = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_flat_valid !== 1'b0) begin
          errors++;
          $display("FAIL release_in_fill: ready=%b flat_valid=%b, required 1 0", o_ready, o_flat_valid);
        end
      end
      i_valid = 1'b1;
      i_data  = sample_t'(pix(kind, off, s / IN_W, s % IN_W));
      step();
    end
    i_valid = 1'b0;
    last_acc_neg = neg_n;
  endtask

  task automatic wait_hold(string name);
    int n;
    n = 0;
    while (!o_flat_valid && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (o_flat_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_hold_timeout: flat_valid=%b, required 1", name, o_flat_valid);
    end
  endtask

  task automatic do_release(bit with_valid);
    i_release = 1'b1;
    if (with_valid) begin
      i_valid = 1'b1;
      i_data  = sample_t'(-5);
      ovr_q.push_back(neg_n + 2);
    end
    step();
    i_release = 1'b0;
    i_valid   = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_flat_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_in_hold: ready=%b flat_valid=%b, required 1 0", o_ready, o_flat_valid);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    neg_n++;
    if (rst !== 1'b1) begin
      prev_vld = 1'b0;
    end else begin
      if (o_overrun === 1'b1) begin
        checks++;
        if (ovr_q.size() == 0) begin
          errors++;
          $display("FAIL overrun_unexpected: pulse at cycle %0d, required none", neg_n);
        end else begin
          int e;
          e = ovr_q.pop_front();
          if (e != neg_n) begin
            errors++;
            $display("FAIL overrun_timing: pulse at cycle %0d, required %0d", neg_n, e);
          end
        end
      end

      if (o_flat_valid === 1'b1 && !prev_vld) begin
        checks++;
        if (neg_n != last_acc_neg + 1 || o_ready !== 1'b0) begin
          errors++;
          $display("FAIL frame_latency: valid at cycle %0d ready=%b, required cycle %0d ready=0",
                   neg_n, o_ready, last_acc_neg + 1);
        end
        checks++;
        if (exp_q.size() < N_OUT) begin
          errors++;
          $display("FAIL frame_unexpected: %0d expected values queued, required %0d", exp_q.size(), N_OUT);
        end else begin
          int bad, first;
          bad = 0;
          first = -1;
          for (int k = 0; k < N_OUT; k++) begin
            cur_exp[k] = exp_q.pop_front();
            if (int'(o_flat_data[k]) != cur_exp[k]) begin
              bad++;
              if (first < 0) first = k;
            end
          end
          if (bad != 0) begin
            errors++;
            $display("FAIL frame_data: %0d bad entries, first k=%0d got %0d required %0d",
                     bad, first, int'(o_flat_data[first]), cur_exp[first]);
          end
        end
        if (spot_cnt_q.size() != 0) begin
          int n;
          n = spot_cnt_q.pop_front();
          for (int i = 0; i < n; i++) begin
            spot_t s;
            s = spot_q.pop_front();
            checks++;
            if (int'(o_flat_data[s.idx]) != s.val) begin
              errors++;
              $display("FAIL spot_out[%0d]: got %0d required %0d", s.idx, int'(o_flat_data[s.idx]), s.val);
            end
          end
        end
        hold_bad = 0;
      end

      if (o_flat_valid === 1'b1) begin
        for (int k = 0; k < N_OUT; k++) if (int'(o_flat_data[k]) != cur_exp[k]) hold_bad++;
      end

      if (o_flat_valid !== 1'b1 && prev_vld) begin
        checks++;
        if (hold_bad != 0) begin
          errors++;
          $display("FAIL hold_stable: %0d entry-cycles changed in HOLD, required 0", hold_bad);
        end
      end
      prev_vld = (o_flat_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    i_valid   = 1'b0;
    i_release = 1'b0;
    i_data    = '0;
    #2 rst = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) step();
    check_reset("reset_held");
    rst = 1'b1;
    step();

    // Ramp frame, back-to-back samples
    push_frame(0, 0);
    spot_cnt_q.push_back(4);
    push_spot(0, 31); push_spot(1, 33); push_spot(15, 91); push_spot(224, 899);
    send_frame(0, 0, 0, IN_W * IN_H, -1);
    wait_hold("ramp");

    // Overrun while frozen, then release with a colliding sample
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data  = sample_t'(12345);
      ovr_q.push_back(neg_n + 2);
      step();
    end
    i_valid = 1'b0;
    step();
    do_release(1'b1);

    // Negative frame: top-left of each block wins
    push_frame(1, 0);
    spot_cnt_q.push_back(3);
    push_spot(0, -1); push_spot(1, -3); push_spot(224, -869);
    send_frame(1, 0, 0, IN_W * IN_H, -1);
    wait_hold("negative");
    do_release(1'b0);

    // Mid-frame async reset after 450 samples, then a fresh ramp
    send_frame(0, 0, 0, 450, -1);
    #2 rst = 1'b0;
    #1 check_reset("reset_midframe");
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    push_frame(0, 0);
    spot_cnt_q.push_back(4);
    push_spot(0, 31); push_spot(1, 33); push_spot(15, 91); push_spot(224, 899);
    send_frame(0, 0, 0, IN_W * IN_H, -1);
    wait_hold("after_reset");
    do_release(1'b0);

    // Two gapped frames, second offset by 1000
    push_frame(0, 0);
    spot_cnt_q.push_back(0);
    send_frame(0, 0, 30, IN_W * IN_H, -1);
    wait_hold("gapped_a");
    do_release(1'b0);
    push_frame(0, 1000);
    spot_cnt_q.push_back(2);
    push_spot(0, 1031); push_spot(224, 1899);
    send_frame(0, 1000, 30, IN_W * IN_H, -1);
    wait_hold("gapped_b");
    do_release(1'b0);

    // Release pulsed during FILL must be ignored
    push_frame(0, 0);
    spot_cnt_q.push_back(1);
    push_spot(224, 899);
    send_frame(0, 0, 0, IN_W * IN_H, 400);
    wait_hold("release_fill");
    do_release(1'b0);

    repeat (4) step();
    checks++;
    if (ovr_q.size() != 0 || exp_q.size() != 0 || spot_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: overrun=%0d frame=%0d spot=%0d, required 0 0 0",
               ovr_q.size(), exp_q.size(), spot_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
